s3g_tx_arbiter: RTL and testbench

//  Shares one s3g_tx packet framer among NREQ packet sources (command replies, async status, debug dumps).

---
 rtl/s3g_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_s3g_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s3g_tx_arbiter.sv
// Shares one s3g_tx packet framer among NREQ sources: arbitrates, latches the winner's
// length/payload, launches the framer, follows its busy flag and returns per-source done/err.
module s3g_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int HIPRI0  = 1,
   parameter int TIMEOUT = 1048576
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [8*NREQ-1:0]         req_len,
   input  logic [128*NREQ-1:0]       req_data,
   output logic [NREQ-1:0]           ack,
   output logic [NREQ-1:0]           done,
   output logic                      err,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      active,
   output logic                      packet_wr,
   output logic [7:0]                payload_len,
   output logic [127:0]              pkt_data,
   input  logic                      tx_busy,
   output logic [2:0]                dbg_state
);

   localparam int IDW = $clog2(NREQ);
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REJECT    = 3'd1,
      S_LAUNCH    = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [WDW-1:0]   wd_q;

   logic             win_found;
   logic [IDW-1:0]   win_idx;
   int               scan_idx;
   logic [7:0]       sel_len;
   logic [127:0]     sel_data;
   logic             wd_expired;

   // Source 0 may pre-empt the scan; otherwise search upward from the last winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      if (HIPRI0 != 0 && req[0]) begin
         win_found = 1'b1;
      end else begin
         for (int i = 1; i <= NREQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!win_found && req[scan_idx]) begin
               win_found = 1'b1;
               win_idx   = IDW'(scan_idx);
            end
         end
      end
   end

   assign sel_len    = req_len[8*int'(win_idx) +: 8];
   assign sel_data   = req_data[128*int'(win_idx) +: 128];
   assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
   assign dbg_state  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= IDW'(NREQ - 1);
         wd_q        <= '0;
         ack         <= '0;
         done        <= '0;
         err         <= 1'b0;
         grant_id    <= '0;
         active      <= 1'b0;
         packet_wr   <= 1'b0;
         payload_len <= '0;
         pkt_data    <= '0;
      end else begin
         ack       <= '0;
         done      <= '0;
         err       <= 1'b0;
         packet_wr <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_found && !tx_busy) begin
                  ack         <= NREQ'(1) << win_idx;
                  grant_id    <= win_idx;
                  active      <= 1'b1;
                  ptr_q       <= win_idx;
                  payload_len <= sel_len;
                  pkt_data    <= sel_data;
                  // The framer length field is only 4 bits wide.
                  state_q     <= (sel_len[7:4] != 4'd0) ? S_REJECT : S_LAUNCH;
               end
            end
            S_REJECT: begin
               done    <= NREQ'(1) << grant_id;
               err     <= 1'b1;
               active  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_LAUNCH: begin
               packet_wr <= 1'b1;
               wd_q      <= '0;
               state_q   <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               wd_q <= wd_q + 1'b1;
               if (wd_expired) begin
                  done    <= NREQ'(1) << grant_id;
                  err     <= 1'b1;
                  active  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (tx_busy) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               wd_q <= wd_q + 1'b1;
               if (!tx_busy) begin
                  done    <= NREQ'(1) << grant_id;
                  active  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (wd_expired) begin
                  done    <= NREQ'(1) << grant_id;
                  err     <= 1'b1;
                  active  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Bench for s3g_tx_arbiter: unit 0 runs HIPRI0=1, unit 1 pure round-robin, both TIMEOUT=50,
// each with a small framer model; transactions are predicted from a pending-set model.
module tb_s3g_tx_arbiter;

   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]     req       [2];
   logic [8*NREQ-1:0]   req_len   [2];
   logic [128*NREQ-1:0] req_data  [2];
   logic [NREQ-1:0]     ack       [2];
   logic [NREQ-1:0]     done      [2];
   logic                err       [2];
   logic [1:0]          grant_id  [2];
   logic                active    [2];
   logic                packet_wr [2];
   logic [7:0]          payload_len [2];
   logic [127:0]        pkt_data  [2];
   logic                tx_busy   [2];
   logic [2:0]          dbg_state [2];

   // framer model controls
   logic                stall [2];
   int                  dur   [2];
   int                  cnt   [2];

   // reference model state
   logic [NREQ-1:0]     pend [2];
   int                  ptr  [2];
   int                  hip  [2] = '{1, 0};
   logic [7:0]          m_len  [2][NREQ];
   logic [127:0]        m_data [2][NREQ];

   int n_checks = 0;
   int n_errors = 0;

   s3g_tx_arbiter #(.NREQ(NREQ), .HIPRI0(1), .TIMEOUT(50)) u_hi (
      .clk(clk), .rst(rst), .req(req[0]), .req_len(req_len[0]), .req_data(req_data[0]),
      .ack(ack[0]), .done(done[0]), .err(err[0]), .grant_id(grant_id[0]), .active(active[0]),
      .packet_wr(packet_wr[0]), .payload_len(payload_len[0]), .pkt_data(pkt_data[0]),
      .tx_busy(tx_busy[0]), .dbg_state(dbg_state[0])
   );

   s3g_tx_arbiter #(.NREQ(NREQ), .HIPRI0(0), .TIMEOUT(50)) u_rr (
      .clk(clk), .rst(rst), .req(req[1]), .req_len(req_len[1]), .req_data(req_data[1]),
      .ack(ack[1]), .done(done[1]), .err(err[1]), .grant_id(grant_id[1]), .active(active[1]),
      .packet_wr(packet_wr[1]), .payload_len(payload_len[1]), .pkt_data(pkt_data[1]),
      .tx_busy(tx_busy[1]), .dbg_state(dbg_state[1])
   );

   // Framer: busy rises at the edge that samples packet_wr, falls dur+1 edges later unless stalled.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            tx_busy[u] <= 1'b0;
            cnt[u]     <= 0;
         end else if (packet_wr[u]) begin
            tx_busy[u] <= 1'b1;
            cnt[u]     <= dur[u];
         end else if (tx_busy[u] && !stall[u]) begin
            if (cnt[u] == 0) tx_busy[u] <= 1'b0;
            else cnt[u] <= cnt[u] - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int u);
      req[u] = pend[u];
      for (int i = 0; i < NREQ; i++) begin
         req_len[u][8*i +: 8]      = m_len[u][i];
         req_data[u][128*i +: 128] = m_data[u][i];
      end
   endtask

   // New requester; data of an already pending source must stay stable until its ack.
   task automatic add_src(input int u, input int i, input logic [7:0] len, input logic [127:0] data);
      if (!pend[u][i]) begin
         pend[u][i]   = 1'b1;
         m_len[u][i]  = len;
         m_data[u][i] = data;
      end
   endtask

   function automatic logic [127:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] rnd_len();
      if ($urandom_range(0, 5) == 0) return 8'($urandom_range(16, 255));
      return 8'($urandom_range(0, 15));
   endfunction

   function automatic int pick(input int u);
      if (hip[u] != 0 && pend[u][0]) return 0;
      for (int i = 1; i <= NREQ; i++) begin
         int k;
         k = (ptr[u] + i) % NREQ;
         if (pend[u][k]) return k;
      end
      return -1;
   endfunction

   task automatic check_idle(input int u, input string tag);
      chk({tag, "_ack"}, ack[u], 0);
      chk({tag, "_done"}, done[u], 0);
      chk({tag, "_err"}, err[u], 0);
      chk({tag, "_active"}, active[u], 0);
      chk({tag, "_pwr"}, packet_wr[u], 0);
      chk({tag, "_gid"}, grant_id[u], 0);
      chk({tag, "_len"}, payload_len[u], 0);
      chk({tag, "_data"}, pkt_data[u], 0);
   endtask

   // mode 0: normal packet, 1: framer stalls (watchdog), 2: reset while framer busy
   task automatic serve(input int u, input int mode, input bit keep);
      int w, lat, nwr, exp_lat, k;
      logic [NREQ-1:0] oh;
      drive(u);
      w  = pick(u);
      oh = NREQ'(1) << w;
      stall[u] = (mode == 1);
      dur[u]   = (mode == 2) ? 30 : (mode == 1) ? 0 : $urandom_range(0, 12);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (ack[u] == 0 && lat < 8);
      chk("ack_lat", lat, 1);
      chk("ack", ack[u], oh);
      chk("grant_id", grant_id[u], w);
      chk("active_on", active[u], 1);
      chk("payload_len", payload_len[u], m_len[u][w]);
      chk("pkt_data", pkt_data[u], m_data[u][w]);
      ptr[u] = w;
      if (!keep) pend[u][w] = 1'b0;
      drive(u);
      if (m_len[u][w] > 8'd15) begin
         stall[u] = 1'b0;
         @(negedge clk);
         chk("rej_done", done[u], oh);
         chk("rej_err", err[u], 1);
         chk("rej_active", active[u], 0);
         chk("rej_pwr", packet_wr[u], 0);
         return;
      end
      @(negedge clk);
      chk("pwr_on", packet_wr[u], 1);
      chk("pwr_nodone", done[u], 0);
      if (mode == 2) begin
         repeat (5) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check_idle(u, "rst_mid");
         rst = 1'b0;
         ptr[0] = NREQ - 1;
         ptr[1] = NREQ - 1;
         stall[u] = 1'b0;
         return;
      end
      lat = 0;
      nwr = 0;
      do begin
         @(negedge clk);
         lat++;
         if (packet_wr[u]) nwr++;
      end while (done[u] == 0 && lat < 80);
      exp_lat = (mode == 1) ? 50 : dur[u] + 3;
      chk("done_lat", lat, exp_lat);
      chk("done", done[u], oh);
      chk("done_err", err[u], (mode == 1));
      chk("done_active", active[u], 0);
      chk("extra_pwr", nwr, 0);
      if (mode == 1) begin
         if (pend[u] == 0) add_src(u, (w + 1) % NREQ, 8'($urandom_range(0, 15)), rnd_data());
         drive(u);
         k = -1;
         for (int i = 0; i < NREQ; i++) if (!pend[u][i] && k < 0) k = i;
         if (k >= 0) req[u][k] = 1'b1;
         repeat (5) begin
            @(negedge clk);
            chk("busy_noack", ack[u], 0);
            chk("busy_nopwr", packet_wr[u], 0);
         end
         drive(u);
         stall[u] = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic random_run(input int u, input int n);
      int r, mode;
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 2) == 0) add_src(u, i, rnd_len(), rnd_data());
         if (pend[u] == 0) add_src(u, $urandom_range(0, NREQ - 1), rnd_len(), rnd_data());
         r = $urandom_range(0, 19);
         mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
         serve(u, mode, $urandom_range(0, 1));
      end
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         pend[u]  = '0;
         ptr[u]   = NREQ - 1;
         stall[u] = 1'b0;
         dur[u]   = 0;
         for (int i = 0; i < NREQ; i++) begin
            m_len[u][i]  = '0;
            m_data[u][i] = '0;
         end
         drive(u);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle(0, "reset_hi");
      check_idle(1, "reset_rr");
      rst = 1'b0;

      // single packet, len 3, bytes 11 22 33
      add_src(1, 1, 8'd3, 128'h33_22_11);
      serve(1, 0, 0);
      // round-robin with requests held: 2, 3, 1 ... following pointer
      for (int i = 1; i < NREQ; i++) add_src(1, i, 8'($urandom_range(0, 15)), rnd_data());
      repeat (4) serve(1, 0, 1);
      while (pend[1] != 0) serve(1, 0, 0);
      // oversize length rejected
      add_src(1, 3, 8'd16, rnd_data());
      serve(1, 0, 0);
      // watchdog abort
      add_src(1, 2, 8'd5, rnd_data());
      serve(1, 1, 0);
      random_run(1, 40);

      // requester 0 dominates while pending
      add_src(0, 0, 8'd4, rnd_data());
      add_src(0, 2, 8'd7, rnd_data());
      repeat (3) serve(0, 0, 1);
      serve(0, 0, 0);
      serve(0, 0, 0);
      // reset while framer busy, source 2 still requesting
      add_src(0, 0, 8'd2, rnd_data());
      add_src(0, 2, 8'd9, rnd_data());
      serve(0, 2, 0);
      serve(0, 0, 0);
      random_run(0, 40);

      pend[0] = '0;
      pend[1] = '0;
      drive(0);
      drive(1);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
